dac_out: RTL and testbench
==========================

# dac_out

Multi-channel, parametrised DAC output stage that sits between the signal-processing datapath and the external parallel DAC pins. It accepts signed samples through a valid/ready handshake and converts them to offset-binary with a runtime DC bias. Samples are presented at a fixed divided update rate, and the stage generates a DAC sample clock whose rising edge falls mid-way through each data-stable window. Underruns hold the last code and are counted.

## Interface
- `CH`, default 2: number of DAC channels.
- `IW`, default 12: input sample width, signed two's complement. Must satisfy `IW >= DW`.
- `DW`, default 10: DAC code width, unsigned offset-binary.
- `DIV`, default 4: clk cycles per DAC sample. Must be even and `>= 2`.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `i_en`, in, 1: stage enable.
- `i_bias`, in, `DW`: signed DC bias, common to all channels.
- `i_valid`, in, 1: sample-vector valid.
- `o_ready`, out, 1: sample-vector accepted when `i_valid && o_ready`.
- `i_data`, in, `CH*IW`: channel k occupies bits `[k*IW +: IW]`.
- `o_data`, out, `CH*DW`: registered DAC codes, channel k occupies bits `[k*DW +: DW]`.
- `dac_clk`, out, 1: registered DAC sample clock.
- `o_underrun_cnt`, out, 16: saturating count of underruns.

## Operation
- **Reset values:**
  - `o_data` is midscale (`2^(DW-1)`) on every channel.
  - `dac_clk` is 0, the period counter `cnt` is 0, and the buffer is empty.
  - `o_underrun_cnt` is 0.
  - `o_ready` is 1 (combinational; see below).
- **Period counter:** `cnt` counts `0..DIV-1` while `i_en` is high. The tick is `cnt == DIV-1`.
- **Conversion (per channel, at acceptance):**
  - `s = i_data_k >>> (IW-DW)`, an arithmetic shift to signed `DW` bits.
  - `u = s + 2^(DW-1) + i_bias`, computed at `DW+2` bits signed.
  - `u` is then saturated to `[0, 2^(DW-1)... 2^DW-1]`, i.e. clamped to `[0, 2^DW-1]` (see Configuration).
- **One-entry buffer:**
  - The converted vector is written on acceptance.
  - `o_ready = !buf_full || tick`.
- **Tick with buffer full:** `o_data` is loaded from the buffer and the buffer is cleared. An acceptance in the same cycle refills the buffer at the same edge.
- **Tick with buffer empty:** this is an underrun.
  - `o_data` holds its value.
  - `o_underrun_cnt` increments, saturating at `16'hFFFF`.
  - A sample accepted in that same cycle goes to the buffer, not to `o_data`.
- **`i_bias`** is sampled at acceptance, not at the tick.
- **`i_en` low:**
  - `cnt` is forced to 0 and `dac_clk` to 0.
  - `o_data` holds its value and no ticks occur.
  - The handshake still operates, so the buffer can fill; the underrun count is frozen.
- **`i_en` reasserted:** counting restarts from `cnt = 0`.
- **Reset asserted mid-operation:** all state returns to the reset values immediately, and the buffered sample is discarded.

## Timing
- **Acceptance:** a sample accepted at edge N is in the buffer after edge N.
- **Output update:** `o_data` changes at the first tick edge after that, so latency is 1 to `DIV` cycles. With continuous valid input, exactly one sample is accepted per `DIV` cycles in steady state.
- **`dac_clk`:** registered, equal to `(cnt_next >= DIV/2)`.
  - It is low for `DIV/2` cycles starting at the edge where `o_data` changes.
  - It is then high for `DIV/2` cycles.
  - Its rising edge therefore comes `DIV/2` cycles after each data change, with a 50% duty cycle.
- **`o_ready`** is combinational from `buf_full` and `cnt`. There is no combinational path from `i_valid`.

## Configuration
- Macro `DAC_OUT_SAT_EN`.
- **Defined:** `u` is clamped to `[0, 2^DW-1]`.
- **Undefined:** `u` wraps modulo `2^DW`, keeping the low `DW` bits. This costs less area, and the wrap is intended for the case where bias headroom is guaranteed upstream.

## Structure
- **Package `dac_pkg`:**
  - function `dac_midscale(DW)`;
  - constant `UNDERRUN_W = 16`;
  - the counter width derived from `DIV` via `$clog2`.
- **Sub-module `dac_conv`:** shift, bias add and saturate/wrap for one channel. It is combinational and instantiated `CH` times in a generate loop. The period counter, buffer and `dac_clk` logic stay in the top level.

## Test plan
Parameters for all scenarios: `CH=2`, `IW=12`, `DW=10`, `DIV=4`.

- **Reset:** assert `rst_n=0` mid-stream -> `o_data={512,512}`, `dac_clk=0`, `o_ready=1`, `o_underrun_cnt=0` immediately.
- **Conversion:** bias=0, ch0=`12'h000`, ch1=`12'h7FF` -> after the next tick `o_data` ch0=512, ch1=1023. `dac_clk` rises 2 cycles after the update.
- **Saturation:**
  - bias=+100, ch1=`12'h7FF` -> 1023 with `DAC_OUT_SAT_EN`, 99 without.
  - bias=-100, ch0=`12'h800` -> 0 with `DAC_OUT_SAT_EN`, 924 without.
- **Underrun:** one sample, then `i_valid=0` for 3 further ticks -> `o_data` is held and `o_underrun_cnt=3`.
- **Back-pressure:** `i_valid` held high with an incrementing ramp -> `o_ready` is high only on tick cycles after the first acceptance. `o_data` steps by exactly one sample per 4 cycles with none dropped.
- **Enable:** drop `i_en` at `cnt=2` -> `dac_clk=0` on the next cycle and `o_data` is frozen. Reassert -> the first tick comes 4 cycles later.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants and helpers for the dac_out output stage.
package dac_pkg;

  localparam int unsigned UNDERRUN_W = 16;

  function automatic int unsigned dac_midscale(int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

  // Period counter width for a given clk-per-sample divider.
  function automatic int unsigned dac_cnt_w(int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/dac_out_if.sv
// Sample-vector valid/ready handshake into the DAC output stage.
interface dac_out_if #(
  parameter int unsigned CH = 2,
  parameter int unsigned IW = 12
) ();
  logic              i_valid;
  logic              o_ready;
  logic [CH*IW-1:0]  i_data;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/dac_conv.sv
// One channel: signed sample -> offset-binary DAC code with DC bias.
// DAC_OUT_SAT_EN selects clamping; otherwise the code wraps modulo 2^DW.
module dac_conv
  import dac_pkg::*;
#(
  parameter int unsigned IW = 12,
  parameter int unsigned DW = 10
) (
  input  logic [IW-1:0] sample,
  input  logic [DW-1:0] bias,
  output logic [DW-1:0] code
);

  localparam logic signed [DW+1:0] MID = (DW+2)'(dac_midscale(DW));

  logic signed [DW+1:0] s_ext;
  logic signed [DW+1:0] b_ext;
  logic signed [DW+1:0] u;

  always_comb begin
    // The shifted sample always fits DW signed bits, so resizing to DW+2 keeps its value.
    s_ext = (DW+2)'($signed(sample) >>> (IW - DW));
    b_ext = (DW+2)'($signed(bias));
    u     = s_ext + MID + b_ext;
`ifdef DAC_OUT_SAT_EN
    if (u[DW+1]) begin
      code = '0;
    end else if (u[DW]) begin
      code = '1;
    end else begin
      code = u[DW-1:0];
    end
`else
    code = DW'(u);
`endif
  end

endmodule

// File: rtl/dac_out.sv
// Multi-channel DAC output stage: one-entry buffer, divided update tick, mid-window dac_clk.
// Build option DAC_OUT_SAT_EN: saturate converted codes instead of wrapping.
module dac_out
  import dac_pkg::*;
#(
  parameter int unsigned CH  = 2,
  parameter int unsigned IW  = 12,
  parameter int unsigned DW  = 10,
  parameter int unsigned DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DW-1:0]         i_bias,
  dac_out_if.slave              bus,
  output logic [CH*DW-1:0]      o_data,
  output logic                  dac_clk,
  output logic [UNDERRUN_W-1:0] o_underrun_cnt
);

  localparam int unsigned   CW  = dac_cnt_w(DIV);
  localparam logic [DW-1:0] MID = DW'(dac_midscale(DW));

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             tick;
  logic             ready;
  logic             accept;
  logic             buf_full;
  logic [CH*DW-1:0] buf_data;
  logic [CH*DW-1:0] conv;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    dac_conv #(
      .IW (IW),
      .DW (DW)
    ) u_conv (
      .sample (bus.i_data[k*IW +: IW]),
      .bias   (i_bias),
      .code   (conv[k*DW +: DW])
    );
  end

  always_comb begin
    tick   = i_en && (cnt == CW'(DIV - 1));
    ready  = !buf_full || tick;
    accept = bus.i_valid && ready;
    if (!i_en || tick) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  assign bus.o_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      dac_clk        <= 1'b0;
      buf_full       <= 1'b0;
      buf_data       <= '0;
      o_data         <= {CH{MID}};
      o_underrun_cnt <= '0;
    end else begin
      cnt     <= cnt_next;
      dac_clk <= (cnt_next >= CW'(DIV / 2));
      if (tick && buf_full) begin
        o_data <= buf_data;
      end
      if (tick && !buf_full && (o_underrun_cnt != '1)) begin
        o_underrun_cnt <= o_underrun_cnt + UNDERRUN_W'(1);
      end
      // A same-cycle acceptance refills the slot being drained by the tick.
      if (accept) begin
        buf_data <= conv;
      end
      buf_full <= accept || (buf_full && !tick);
    end
  end

endmodule

// File: tb/tb_dac_out.sv
// Self-checking bench for dac_out: cycle model plus scoreboard of converted vectors.
module tb_dac_out;
  import dac_pkg::*;

  localparam int CH  = 2;
  localparam int IW  = 12;
  localparam int DW  = 10;
  localparam int DIV = 4;
  localparam logic [CH*DW-1:0] MIDV = {CH{10'd512}};
`ifdef DAC_OUT_SAT_EN
  localparam logic [DW-1:0] SAT_HI = 10'd1023;
  localparam logic [DW-1:0] SAT_LO = 10'd0;
`else
  localparam logic [DW-1:0] SAT_HI = 10'd99;
  localparam logic [DW-1:0] SAT_LO = 10'd924;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_en = 1'b0;
  logic [DW-1:0]    i_bias = '0;
  logic [CH*DW-1:0] o_data;
  logic             dac_clk;
  logic [15:0]      o_underrun_cnt;

  dac_out_if #(.CH(CH), .IW(IW)) bus ();

  dac_out #(.CH(CH), .IW(IW), .DW(DW), .DIV(DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (i_en),
    .i_bias         (i_bias),
    .bus            (bus),
    .o_data         (o_data),
    .dac_clk        (dac_clk),
    .o_underrun_cnt (o_underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CH*DW-1:0] sb[$];
  logic [CH*DW-1:0] m_data;
  int               m_cnt;
  int               m_under;
  logic             m_dac, m_tick, m_acc, m_ready, obs_ready;

  function automatic logic [DW-1:0] conv_ch(logic [IW-1:0] smp, logic [DW-1:0] b);
    int sv, bv, u;
    sv = int'($signed(smp)) >>> (IW - DW);
    bv = int'($signed(b));
    u  = sv + 512 + bv;
`ifdef DAC_OUT_SAT_EN
    if (u < 0) u = 0;
    if (u > 1023) u = 1023;
`endif
    return DW'(u);
  endfunction

  function automatic logic [CH*DW-1:0] vec_model(logic [CH*IW-1:0] d, logic [DW-1:0] b);
    logic [CH*DW-1:0] r;
    for (int k = 0; k < CH; k++) r[k*DW +: DW] = conv_ch(d[k*IW +: IW], b);
    return r;
  endfunction

  function automatic void reset_model();
    sb.delete();
    m_data  = MIDV;
    m_cnt   = 0;
    m_under = 0;
    m_dac   = 1'b0;
  endfunction

  // Advances one clock and updates the model; leaves time at posedge+1.
  task automatic clk_cycle();
    int nxt;
    #1;
    m_tick    = i_en && (m_cnt == DIV - 1);
    m_ready   = (sb.size() == 0) || m_tick;
    obs_ready = bus.o_ready;
    m_acc     = bus.i_valid && bus.o_ready;
    if (m_tick) begin
      if (sb.size() > 0) m_data = sb.pop_front();
      else if (m_under < 16'hFFFF) m_under++;
    end
    if (m_acc) sb.push_back(vec_model(bus.i_data, i_bias));
    nxt   = (!i_en || m_tick) ? 0 : m_cnt + 1;
    m_dac = i_en && (nxt >= DIV / 2);
    @(posedge clk);
    #1;
    m_cnt = nxt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (o_data !== MIDV) begin errors++; $display("FAIL reset_data: got %h expected %h", o_data, MIDV); end
    checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL reset_dac_clk: got %b expected 0", dac_clk); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
    checks++; if (o_underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_underrun: got %0d expected 0", o_underrun_cnt); end
  endtask

  task automatic test_conversion();
    bit upd = 0;
    i_en = 1'b1; i_bias = '0;
    bus.i_valid = 1'b1; bus.i_data = {12'h7FF, 12'h000};
    clk_cycle();
    bus.i_valid = 1'b0;
    checks++; if (obs_ready !== m_ready || !m_acc) begin errors++; $display("FAIL conv_accept: got ready %b expected %b", obs_ready, m_ready); end
    for (int i = 0; i < 2 * DIV && !upd; i++) begin
      clk_cycle();
      upd = m_tick;
    end
    checks++; if (!upd) begin errors++; $display("FAIL conv_timeout: got no tick expected tick within %0d cycles", 2 * DIV); end
    checks++; if (o_data !== {10'd1023, 10'd512}) begin errors++; $display("FAIL conv_data: got %h expected %h", o_data, {10'd1023, 10'd512}); end
    checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL conv_dclk0: got %b expected 0", dac_clk); end
    clk_cycle();
    checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL conv_dclk1: got %b expected 0", dac_clk); end
    clk_cycle();
    checks++; if (dac_clk !== 1'b1 || dac_clk !== m_dac) begin errors++; $display("FAIL conv_dclk2: got %b expected 1", dac_clk); end
  endtask

  task automatic test_saturation();
    logic [CH*IW-1:0] din [2];
    logic [DW-1:0]    bv  [2];
    bit upd;
    din[0] = {12'h7FF, 12'h000}; bv[0] = DW'(100);
    din[1] = {12'h000, 12'h800}; bv[1] = DW'(-100);
    for (int t = 0; t < 2; t++) begin
      upd = 0;
      bus.i_valid = 1'b1; bus.i_data = din[t]; i_bias = bv[t];
      clk_cycle();
      bus.i_valid = 1'b0; i_bias = '0;
      checks++; if (!m_acc) begin errors++; $display("FAIL sat_accept%0d: got ready %b expected 1", t, obs_ready); end
      for (int i = 0; i < 2 * DIV && !upd; i++) begin
        clk_cycle();
        upd = m_tick;
      end
      checks++; if (o_data !== m_data) begin errors++; $display("FAIL sat_vec%0d: got %h expected %h", t, o_data, m_data); end
    end
    checks++; if (m_data[0 +: DW] !== SAT_LO || o_data[0 +: DW] !== SAT_LO) begin errors++; $display("FAIL sat_lo: got %0d expected %0d", o_data[0 +: DW], SAT_LO); end
  endtask

  task automatic test_saturation_hi();
    bit upd = 0;
    bus.i_valid = 1'b1; bus.i_data = {12'h7FF, 12'h000}; i_bias = DW'(100);
    clk_cycle();
    bus.i_valid = 1'b0; i_bias = '0;
    for (int i = 0; i < 2 * DIV && !upd; i++) begin
      clk_cycle();
      upd = m_tick;
    end
    checks++; if (o_data[DW +: DW] !== SAT_HI) begin errors++; $display("FAIL sat_hi: got %0d expected %0d", o_data[DW +: DW], SAT_HI); end
    checks++; if (o_data[0 +: DW] !== 10'd612) begin errors++; $display("FAIL sat_hi_ch0: got %0d expected 612", o_data[0 +: DW]); end
  endtask

  task automatic test_underrun();
    int ticks = 0;
    do_reset();
    i_en = 1'b1; i_bias = '0;
    bus.i_valid = 1'b1; bus.i_data = {12'h100, 12'h200};
    clk_cycle();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 6 * DIV && ticks < 4; i++) begin
      clk_cycle();
      if (m_tick) ticks++;
      checks++; if (o_data !== m_data) begin errors++; $display("FAIL under_hold: got %h expected %h", o_data, m_data); end
    end
    checks++; if (ticks != 4) begin errors++; $display("FAIL under_timeout: got %0d ticks expected 4", ticks); end
    checks++; if (o_data !== {10'd576, 10'd640}) begin errors++; $display("FAIL under_data: got %h expected %h", o_data, {10'd576, 10'd640}); end
    checks++; if (o_underrun_cnt !== 16'd3) begin errors++; $display("FAIL under_cnt: got %0d expected 3", o_underrun_cnt); end
  endtask

  task automatic test_back_to_back();
    int n = 0, upd = 0;
    bit started = 0;
    do_reset();
    i_en = 1'b1; i_bias = '0;
    bus.i_valid = 1'b1; bus.i_data = '0;
    for (int i = 0; i < 10 * DIV; i++) begin
      clk_cycle();
      checks++; if (obs_ready !== m_ready) begin errors++; $display("FAIL b2b_ready: got %b expected %b", obs_ready, m_ready); end
      if (started) begin
        checks++; if (obs_ready !== m_tick) begin errors++; $display("FAIL b2b_ready_tick: got %b expected %b", obs_ready, m_tick); end
      end
      if (m_tick) begin
        checks++; if (o_data[0 +: DW] !== DW'(512 + upd)) begin errors++; $display("FAIL b2b_step: got %0d expected %0d", o_data[0 +: DW], 512 + upd); end
        upd++;
      end
      checks++; if (o_data !== m_data) begin errors++; $display("FAIL b2b_data: got %h expected %h", o_data, m_data); end
      if (m_acc) begin
        started = 1;
        n++;
        bus.i_data = {12'(n * 8), 12'(n * 4)};
      end
    end
    bus.i_valid = 1'b0;
    checks++; if (upd != 10 || o_underrun_cnt !== 16'd0) begin errors++; $display("FAIL b2b_count: got %0d updates/%0d underruns expected 10/0", upd, o_underrun_cnt); end
  endtask

  task automatic test_enable();
    logic [CH*DW-1:0] frozen;
    int first = 0;
    do_reset();
    i_en = 1'b1; i_bias = '0;
    bus.i_valid = 1'b1; bus.i_data = {12'h123, 12'h456};
    for (int i = 0; i < 2 * DIV && m_cnt != 2; i++) clk_cycle();
    checks++; if (m_cnt != 2 || dac_clk !== 1'b1) begin errors++; $display("FAIL en_pre: got dac_clk %b expected 1 at cnt 2", dac_clk); end
    i_en = 1'b0;
    clk_cycle();
    checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL en_dclk: got %b expected 0", dac_clk); end
    frozen = o_data;
    for (int i = 0; i < 3 * DIV; i++) begin
      clk_cycle();
      checks++; if (o_data !== frozen || dac_clk !== 1'b0 || obs_ready !== m_ready) begin errors++; $display("FAIL en_frozen: got %h/%b/%b expected %h/0/%b", o_data, dac_clk, obs_ready, frozen, m_ready); end
    end
    checks++; if (o_underrun_cnt !== 16'd0) begin errors++; $display("FAIL en_under: got %0d expected 0", o_underrun_cnt); end
    i_en = 1'b1;
    for (int i = 1; i <= 2 * DIV && first == 0; i++) begin
      clk_cycle();
      if (o_data !== frozen) first = i;
    end
    checks++; if (first != DIV) begin errors++; $display("FAIL en_restart: got first tick after %0d cycles expected %0d", first, DIV); end
    checks++; if (o_data !== m_data || o_data !== vec_model({12'h123, 12'h456}, '0)) begin errors++; $display("FAIL en_data: got %h expected %h", o_data, m_data); end
  endtask

  task automatic test_reset_mid();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) clk_cycle();
    bus.i_valid = 1'b1; bus.i_data = {12'h400, 12'h400};
    clk_cycle();
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_data !== MIDV) begin errors++; $display("FAIL rmid_data: got %h expected %h", o_data, MIDV); end
    checks++; if (dac_clk !== 1'b0 || bus.o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ctl: got dac_clk %b ready %b expected 0 1", dac_clk, bus.o_ready); end
    checks++; if (o_underrun_cnt !== 16'd0) begin errors++; $display("FAIL rmid_under: got %0d expected 0", o_underrun_cnt); end
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DIV; i++) clk_cycle();
    checks++; if (o_data !== MIDV || o_underrun_cnt !== 16'd1) begin errors++; $display("FAIL rmid_discard: got %h/%0d expected %h/1", o_data, o_underrun_cnt, MIDV); end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_conversion();
    test_saturation();
    test_saturation_hi();
    test_underrun();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
